// File: rtl/xgmii_pkg.sv
`default_nettype none
// xgmii_pkg: XGMII character constants and arbiter state encoding shared by the TX arbiter files.
// Rev 1.0
package xgmii_pkg;

  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;
  localparam logic [7:0] CH_IDLE  = 8'h07;
  localparam logic [7:0] CH_ERROR = 8'hFE;

  localparam logic [63:0] XGMII_IDLE     = {8{CH_IDLE}};
  localparam logic [63:0] XGMII_ERROR    = {8{CH_ERROR}};
  localparam logic [7:0]  XGMII_CTRL_ALL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XMIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_IFG   = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/xgmii_tx_arb_if.sv
`default_nettype none
// xgmii_tx_arb_if: requester-side bundle (eligibility, frame words, handshake) of xgmii_tx_arb.
// Rev 1.0
interface xgmii_tx_arb_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]    req_en;
  logic [N_REQ*64-1:0] s_txd;
  logic [N_REQ*8-1:0]  s_txc;
  logic [N_REQ-1:0]    s_valid;
  logic [N_REQ-1:0]    s_last;
  logic [N_REQ-1:0]    s_ready;

  modport master (
    output req_en,
    output s_txd,
    output s_txc,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  req_en,
    input  s_txd,
    input  s_txc,
    input  s_valid,
    input  s_last,
    output s_ready
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// rr_arbiter: combinational one-hot picker of the first request at or after a rotating pointer.
// Rev 1.0
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  function automatic int wrap_idx(input int p, input int k);
    return (p + k >= N) ? (p + k - N) : (p + k);
  endfunction

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_o && req_i[wrap_idx(int'(ptr_i), k)]) begin
        any_o                            = 1'b1;
        gnt_o[wrap_idx(int'(ptr_i), k)]  = 1'b1;
        idx_o                            = PW'(wrap_idx(int'(ptr_i), k));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xgmii_tx_arb.sv
`default_nettype none
// xgmii_tx_arb: frame-atomic round-robin arbiter sharing one 64-bit XGMII TX link.
// Rev 1.0 - IFG enforcement, idle fill, underrun abort with error codes, saturating counters.
module xgmii_tx_arb
  import xgmii_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int IFG_WORDS = 2,
  parameter int CNT_W     = 16
) (
  input  logic             xgmii_tx_clk,
  input  logic             xgmii_tx_rst_n,
  xgmii_tx_arb_if.slave    s_if,
  output logic [63:0]      xgmii_txd,
  output logic [7:0]       xgmii_txc,
  output logic [N_REQ-1:0] grant,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] underrun_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int IFG_W = (IFG_WORDS > 1) ? $clog2(IFG_WORDS + 1) : 1;
  localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_WORDS);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] idx_q, idx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [IFG_W-1:0] ifg_q, ifg_d;
  logic [63:0]      txd_q, txd_d;
  logic [7:0]       txc_q, txc_d;
  logic [CNT_W-1:0] frm_q, frm_d;
  logic [CNT_W-1:0] urn_q, urn_d;

  logic [N_REQ-1:0] w_cand;
  logic [N_REQ-1:0] w_pick_gnt;
  logic [PTR_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic [63:0]      w_sel_txd;
  logic [7:0]       w_sel_txc;
  logic [PTR_W-1:0] w_ptr_next;

  // req_en only matters here: once granted, the owner keeps the link regardless of it.
  assign w_cand = s_if.s_valid & s_if.req_en;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PTR_W)
  ) u_rr (
    .req_i (w_cand),
    .ptr_i (ptr_q),
    .gnt_o (w_pick_gnt),
    .idx_o (w_pick_idx),
    .any_o (w_pick_any)
  );

  assign w_sel_valid = s_if.s_valid[idx_q];
  assign w_sel_last  = s_if.s_last[idx_q];
  assign w_sel_txd   = s_if.s_txd[int'(idx_q) * 64 +: 64];
  assign w_sel_txc   = s_if.s_txc[int'(idx_q) * 8 +: 8];
  assign w_ptr_next  = (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + PTR_W'(1);

  always_ff @(posedge xgmii_tx_clk or negedge xgmii_tx_rst_n) begin
    if (!xgmii_tx_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      ifg_q   <= '0;
      txd_q   <= XGMII_IDLE;
      txc_q   <= XGMII_CTRL_ALL;
      frm_q   <= '0;
      urn_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      ifg_q   <= ifg_d;
      txd_q   <= txd_d;
      txc_q   <= txc_d;
      frm_q   <= frm_d;
      urn_q   <= urn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    ifg_d   = ifg_q;
    txd_d   = XGMII_IDLE;
    txc_d   = XGMII_CTRL_ALL;
    frm_d   = frm_q;
    urn_d   = urn_q;
    case (state_q)
      ST_IDLE: begin
        if (w_pick_any) begin
          grant_d = w_pick_gnt;
          idx_d   = w_pick_idx;
          state_d = ST_XMIT;
        end
      end
      ST_XMIT: begin
        if (w_sel_valid) begin
          txd_d = w_sel_txd;
          txc_d = w_sel_txc;
          if (w_sel_last) begin
            frm_d   = (&frm_q) ? frm_q : frm_q + CNT_W'(1);
            ptr_d   = w_ptr_next;
            ifg_d   = IFG_LOAD;
            state_d = ST_IFG;
          end
        end else begin
          // Any gap after the first word poisons the frame on the wire.
          txd_d   = XGMII_ERROR;
          txc_d   = XGMII_CTRL_ALL;
          urn_d   = (&urn_q) ? urn_q : urn_q + CNT_W'(1);
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_sel_valid && w_sel_last) begin
          ptr_d   = w_ptr_next;
          ifg_d   = IFG_LOAD;
          state_d = ST_IFG;
        end
      end
      ST_IFG: begin
        if (ifg_q <= IFG_W'(1)) begin
          ifg_d   = '0;
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          ifg_d = ifg_q - IFG_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_if.s_ready = ((state_q == ST_XMIT) || (state_q == ST_DRAIN)) ? grant_q : '0;
  end

  assign xgmii_txd    = txd_q;
  assign xgmii_txc    = txc_q;
  assign grant        = grant_q;
  assign frame_cnt    = frm_q;
  assign underrun_cnt = urn_q;

endmodule
`default_nettype wire
